// File: rtl/uart_pkg.sv
// Shared UART constants: data width and default receive-FIFO sizing.
package uart_pkg;

    localparam int unsigned DATA_W               = 8;
    localparam int unsigned FIFO_DEPTH_DEFAULT   = 16;
    localparam int unsigned TIMEOUT_BITS_DEFAULT = 40;

    typedef logic [DATA_W-1:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Receive FIFO storage: DEPTH x DATA_W register array.
// Ports:
//   i_clk   - clock
//   i_we    - write enable
//   i_waddr - write address
//   i_wdata - write data
//   i_raddr - read address
//   o_rdata - read data (asynchronous)
// Contents are intentionally not reset.
module uart_rx_fifo_mem
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = FIFO_DEPTH_DEFAULT,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [AW-1:0]     i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Asynchronous read port
    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive buffer: first-word-fall-through FIFO with sticky overrun and
// character-timeout flags plus a registered interrupt request.
// Ports:
//   iCLK, iRESET          - clock, async active-high reset
//   iRX_DATA, iRX_DATA_EN - received byte and its one-cycle valid pulse
//   iRX_STOP              - one pulse per idle bit period
//   iRD_EN                - pop head entry
//   iFLUSH                - discard all entries
//   iTHRESHOLD            - level interrupt threshold (0 disables)
//   iOVR_CLR, iTO_CLR     - clear sticky flags
//   oRD_DATA              - head entry, 0 when empty
//   oEMPTY, oFULL, oCOUNT - fill status
//   oOVERRUN, oTIMEOUT    - sticky flags
//   oIRQ                  - registered OR of level, overrun, timeout
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH        = FIFO_DEPTH_DEFAULT,
    parameter int unsigned AW           = $clog2(DEPTH),
    parameter int unsigned TIMEOUT_BITS = TIMEOUT_BITS_DEFAULT
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic [DATA_W-1:0] iRX_DATA,
    input  logic              iRX_DATA_EN,
    input  logic              iRX_STOP,
    input  logic              iRD_EN,
    input  logic              iFLUSH,
    input  logic [AW:0]       iTHRESHOLD,
    input  logic              iOVR_CLR,
    input  logic              iTO_CLR,
    output logic [DATA_W-1:0] oRD_DATA,
    output logic              oEMPTY,
    output logic              oFULL,
    output logic [AW:0]       oCOUNT,
    output logic              oOVERRUN,
    output logic              oTIMEOUT,
    output logic              oIRQ
);

    localparam int unsigned CW       = $clog2(TIMEOUT_BITS + 1);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_BITS);

    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [AW:0]       r_count;
    logic              r_empty;
    logic              r_full;
    logic              r_overrun;
    logic              r_timeout;
    logic [CW-1:0]     r_to_cnt;
    logic              r_to_fired;
    logic              r_irq;

    logic              w_wr_acc;
    logic              w_rd_acc;
    logic              w_ovr_set;
    logic [AW:0]       w_count_nxt;
    logic              w_to_cnt_clr;
    logic              w_to_sat;
    logic              w_to_set;
    logic              w_level;
    logic [DATA_W-1:0] w_mem_rdata;

    // Accept/drop decisions; flush overrides everything in its cycle
    always_comb begin
        w_wr_acc     = iRX_DATA_EN && !iFLUSH && (!r_full || iRD_EN);
        w_rd_acc     = iRD_EN && !iFLUSH && !r_empty;
        w_ovr_set    = iRX_DATA_EN && !iFLUSH && r_full && !iRD_EN;
        w_count_nxt  = iFLUSH ? '0
                     : r_count + (AW+1)'(w_wr_acc) - (AW+1)'(w_rd_acc);
        w_to_cnt_clr = w_wr_acc || w_rd_acc || iFLUSH || r_empty;
        w_to_sat     = (r_to_cnt == TO_MAX);
        // Fire only once per idle episode; r_to_fired re-arms when counter clears
        w_to_set     = w_to_sat && !r_to_fired;
        w_level      = (iTHRESHOLD != '0) && (r_count >= iTHRESHOLD);
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .i_clk   (iCLK),
        .i_we    (w_wr_acc),
        .i_waddr (r_wr_ptr),
        .i_wdata (iRX_DATA),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_mem_rdata)
    );

    // Pointers and fill status
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
        end else begin
            if (iFLUSH) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
                if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == FULL_CNT);
        end
    end

    // Character-timeout counter, saturating
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_to_cnt   <= '0;
            r_to_fired <= 1'b0;
        end else if (w_to_cnt_clr) begin
            r_to_cnt   <= '0;
            r_to_fired <= 1'b0;
        end else begin
            if (w_to_set) r_to_fired <= 1'b1;
            if (iRX_STOP && !w_to_sat) r_to_cnt <= r_to_cnt + CW'(1);
        end
    end

    // Sticky flags (set wins over clear) and interrupt
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            r_overrun <= 1'b0;
            r_timeout <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            if (w_ovr_set)     r_overrun <= 1'b1;
            else if (iOVR_CLR) r_overrun <= 1'b0;

            if (w_to_set)                   r_timeout <= 1'b1;
            else if (iTO_CLR || w_rd_acc)   r_timeout <= 1'b0;

            r_irq <= w_level || r_overrun || r_timeout;
        end
    end

    assign oRD_DATA = r_empty ? '0 : w_mem_rdata;
    assign oEMPTY   = r_empty;
    assign oFULL    = r_full;
    assign oCOUNT   = r_count;
    assign oOVERRUN = r_overrun;
    assign oTIMEOUT = r_timeout;
    assign oIRQ     = r_irq;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios then random traffic,
// compared each cycle against a queue-based reference model.
module tb_uart_rx_fifo;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int TO_N  = 40;

    logic          iCLK = 1'b0;
    logic          iRESET;
    logic [7:0]    iRX_DATA;
    logic          iRX_DATA_EN;
    logic          iRX_STOP;
    logic          iRD_EN;
    logic          iFLUSH;
    logic [AW:0]   iTHRESHOLD;
    logic          iOVR_CLR;
    logic          iTO_CLR;
    logic [7:0]    oRD_DATA;
    logic          oEMPTY;
    logic          oFULL;
    logic [AW:0]   oCOUNT;
    logic          oOVERRUN;
    logic          oTIMEOUT;
    logic          oIRQ;

    uart_rx_fifo #(
        .DEPTH        (DEPTH),
        .AW           (AW),
        .TIMEOUT_BITS (TO_N)
    ) dut (
        .iCLK        (iCLK),
        .iRESET      (iRESET),
        .iRX_DATA    (iRX_DATA),
        .iRX_DATA_EN (iRX_DATA_EN),
        .iRX_STOP    (iRX_STOP),
        .iRD_EN      (iRD_EN),
        .iFLUSH      (iFLUSH),
        .iTHRESHOLD  (iTHRESHOLD),
        .iOVR_CLR    (iOVR_CLR),
        .iTO_CLR     (iTO_CLR),
        .oRD_DATA    (oRD_DATA),
        .oEMPTY      (oEMPTY),
        .oFULL       (oFULL),
        .oCOUNT      (oCOUNT),
        .oOVERRUN    (oOVERRUN),
        .oTIMEOUT    (oTIMEOUT),
        .oIRQ        (oIRQ)
    );

    always #5 iCLK = ~iCLK;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [7:0] q[$];
    bit         m_ovr;
    bit         m_to;
    bit         m_irq;
    bit         m_fired;
    int         m_idle;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ovr   = 1'b0;
        m_to    = 1'b0;
        m_irq   = 1'b0;
        m_fired = 1'b0;
        m_idle  = 0;
    endtask

    task automatic check_all();
        logic [7:0] head;
        head = (q.size() != 0) ? q[0] : 8'h00;
        check("count",   32'(oCOUNT),   32'(q.size()));
        check("empty",   32'(oEMPTY),   32'(q.size() == 0));
        check("full",    32'(oFULL),    32'(q.size() == DEPTH));
        check("rd_data", 32'(oRD_DATA), 32'(head));
        check("overrun", 32'(oOVERRUN), 32'(m_ovr));
        check("timeout", 32'(oTIMEOUT), 32'(m_to));
        check("irq",     32'(oIRQ),     32'(m_irq));
    endtask

    // One clock: drive inputs, advance the model on the edge, then compare
    task automatic step(input bit en, input logic [7:0] d, input bit rd, input bit stop,
                        input bit fl, input bit oc, input bit tc);
        int sz;
        bit wr_ok, rd_ok, ovr_set, to_set, irq_n, idle_clr;
        iRX_DATA_EN = en;
        iRX_DATA    = d;
        iRD_EN      = rd;
        iRX_STOP    = stop;
        iFLUSH      = fl;
        iOVR_CLR    = oc;
        iTO_CLR     = tc;
        @(posedge iCLK);
        sz       = q.size();
        wr_ok    = en && !fl && (sz < DEPTH || rd);
        rd_ok    = rd && !fl && (sz > 0);
        ovr_set  = en && !fl && (sz == DEPTH) && !rd;
        to_set   = (m_idle == TO_N) && !m_fired;
        irq_n    = ((iTHRESHOLD != 0) && (sz >= int'(iTHRESHOLD))) || m_ovr || m_to;
        idle_clr = wr_ok || rd_ok || fl || (sz == 0);
        if (ovr_set) m_ovr = 1'b1;
        else if (oc) m_ovr = 1'b0;
        if (to_set)             m_to = 1'b1;
        else if (tc || rd_ok)   m_to = 1'b0;
        if (idle_clr) begin
            m_idle  = 0;
            m_fired = 1'b0;
        end else begin
            if (to_set) m_fired = 1'b1;
            if (stop && m_idle < TO_N) m_idle++;
        end
        m_irq = irq_n;
        if (fl) q.delete();
        else begin
            if (rd_ok) void'(q.pop_front());
            if (wr_ok) q.push_back(d);
        end
        #1;
        iRX_DATA_EN = 1'b0;
        iRD_EN      = 1'b0;
        iRX_STOP    = 1'b0;
        iFLUSH      = 1'b0;
        iOVR_CLR    = 1'b0;
        iTO_CLR     = 1'b0;
        check_all();
    endtask

    task automatic wr(input logic [7:0] d);  step(1, d, 0, 0, 0, 0, 0); endtask
    task automatic pop();                     step(0, 0, 1, 0, 0, 0, 0); endtask
    task automatic idle();                    step(0, 0, 0, 0, 0, 0, 0); endtask
    task automatic clean();                   step(0, 0, 0, 0, 1, 1, 1); endtask

    initial begin
        iRESET      = 1'b1;
        iRX_DATA    = '0;
        iRX_DATA_EN = 1'b0;
        iRX_STOP    = 1'b0;
        iRD_EN      = 1'b0;
        iFLUSH      = 1'b0;
        iTHRESHOLD  = '0;
        iOVR_CLR    = 1'b0;
        iTO_CLR     = 1'b0;
        model_reset();
        repeat (2) @(posedge iCLK);
        #1;
        check_all();
        iRESET = 1'b0;
        idle();

        // Basic write / FWFT / pop
        wr(8'h55);
        check("first_word", 32'(oRD_DATA), 32'h55);
        wr(8'hA3);
        pop();
        check("second_word", 32'(oRD_DATA), 32'hA3);
        pop();
        check("drained", 32'(oCOUNT), 32'd0);

        // Fill, overrun, drain in order
        for (int i = 0; i < DEPTH; i++) wr(8'(i + 8'h20));
        wr(8'h7E);
        check("ovr_set", 32'(oOVERRUN), 32'd1);
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_order", 32'(oRD_DATA), 32'(i + 8'h20));
            pop();
        end
        step(0, 0, 0, 0, 0, 1, 0);
        check("ovr_clr", 32'(oOVERRUN), 32'd0);

        // Write+pop while full and while empty
        for (int i = 0; i < DEPTH; i++) wr(8'(i));
        step(1, 8'h11, 1, 0, 0, 0, 0);
        check("full_wr_pop_cnt", 32'(oCOUNT), 32'd16);
        for (int i = 0; i < DEPTH - 1; i++) pop();
        check("late_11", 32'(oRD_DATA), 32'h11);
        pop();
        step(1, 8'h99, 1, 0, 0, 0, 0);
        check("empty_wr_pop_cnt", 32'(oCOUNT), 32'd1);
        clean();

        // Character timeout
        wr(8'h42);
        for (int i = 0; i < TO_N; i++) step(0, 0, 0, 1, 0, 0, 0);
        check("to_not_yet", 32'(oTIMEOUT), 32'd0);
        idle();
        check("to_set", 32'(oTIMEOUT), 32'd1);
        idle();
        check("to_irq", 32'(oIRQ), 32'd1);
        pop();
        check("to_pop_clr", 32'(oTIMEOUT), 32'd0);
        wr(8'h43);
        for (int i = 0; i < TO_N - 1; i++) step(0, 0, 0, 1, 0, 0, 0);
        wr(8'h44);
        repeat (3) idle();
        check("to_avoided", 32'(oTIMEOUT), 32'd0);
        clean();
        idle();

        // Level threshold
        iTHRESHOLD = 5'd4;
        for (int i = 0; i < 3; i++) wr(8'(8'hB0 + i));
        idle();
        check("lvl_below", 32'(oIRQ), 32'd0);
        wr(8'hB3);
        idle();
        check("lvl_hit", 32'(oIRQ), 32'd1);
        iTHRESHOLD = 5'd0;
        for (int i = 0; i < DEPTH - 4; i++) wr(8'(i));
        repeat (2) idle();
        check("lvl_disabled", 32'(oIRQ), 32'd0);
        clean();

        // Flush beats a same-cycle write
        for (int i = 0; i < 5; i++) wr(8'(8'hC0 + i));
        step(1, 8'hEE, 0, 0, 1, 0, 0);
        check("flush_cnt", 32'(oCOUNT), 32'd0);
        check("flush_ovr", 32'(oOVERRUN), 32'd0);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 99) == 0) iTHRESHOLD = 5'($urandom_range(0, DEPTH));
            step($urandom_range(0, 99) < 55, 8'($urandom), $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 60, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 49) == 0, $urandom_range(0, 49) == 0);
        end

        // Asynchronous reset mid-fill
        clean();
        for (int i = 0; i < 6; i++) wr(8'(8'hD0 + i));
        #2;
        iRESET = 1'b1;
        #1;
        model_reset();
        check_all();
        @(posedge iCLK);
        #1;
        iRESET = 1'b0;
        wr(8'h5A);
        check("post_reset", 32'(oRD_DATA), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive buffer directly downstream of the UART receive controller. It captures each byte delivered on the controller's data/enable pulse into a first-word-fall-through FIFO, and presents it to the APB register block through a pop interface. It also raises sticky overrun and character-timeout flags and a registered interrupt request.

## Interface
Parameters:
- DEPTH, 16, FIFO entries; power of two, 2..256
- AW, $clog2(DEPTH), pointer width; count width is AW+1
- TIMEOUT_BITS, 40, idle bit periods (iRX_STOP pulses) before timeout; ≥1

Ports:
- iCLK  in  1  single clock
- iRESET  in  1  asynchronous, active-high reset
- iRX_DATA  in  8  received byte from receive controller
- iRX_DATA_EN  in  1  one-cycle pulse; iRX_DATA valid
- iRX_STOP  in  1  one-cycle pulse per idle bit period from receive controller
- iRD_EN  in  1  pop head entry (APB read of data register)
- iFLUSH  in  1  discard all entries
- iTHRESHOLD  in  AW+1  level-interrupt threshold; 0 disables level term
- iOVR_CLR  in  1  clear oOVERRUN
- iTO_CLR  in  1  clear oTIMEOUT
- oRD_DATA  out  8  head entry (FWFT); 0 when empty
- oEMPTY  out  1  no entries
- oFULL  out  1  DEPTH entries
- oCOUNT  out  AW+1  entries held, 0..DEPTH
- oOVERRUN  out  1  sticky: byte dropped because full
- oTIMEOUT  out  1  sticky: data waiting, no activity for TIMEOUT_BITS bit periods
- oIRQ  out  1  registered OR of level, overrun, timeout

## Operation
- Reset: pointers, count, timeout counter = 0; oEMPTY=1, oFULL=0, oCOUNT=0, oOVERRUN=0, oTIMEOUT=0, oIRQ=0, oRD_DATA=0. Memory contents are not reset.
- Write: iRX_DATA_EN with !oFULL stores the byte at wr_ptr; wr_ptr++ mod DEPTH.
- Write while full, no pop: byte dropped, oOVERRUN set, FIFO unchanged.
- Pop: iRD_EN with !oEMPTY advances rd_ptr mod DEPTH. iRD_EN while empty is ignored (no underflow, no flag).
- Simultaneous write+pop:
  - full: both accepted; count unchanged; no overrun.
  - empty: write accepted; pop ignored.
  - otherwise: both accepted; count unchanged.
- iFLUSH: pointers and count to 0 and timeout counter cleared. It has priority over a same-cycle write or pop, and that write is discarded without setting overrun. Sticky flags are unaffected.
- Sticky flags: a set event has priority over a same-cycle clear. oTIMEOUT also clears on any accepted pop.
- Timeout counter, saturating at TIMEOUT_BITS:
  - clears on an accepted write, an accepted pop, flush, or when the FIFO is empty;
  - otherwise increments on iRX_STOP.
  - oTIMEOUT sets in the cycle after the counter reaches TIMEOUT_BITS.
  - oTIMEOUT sets once per idle episode; the counter holds at saturation until cleared.
- Level term: (iTHRESHOLD != 0) && (count ≥ iTHRESHOLD), evaluated on the registered count.

## Timing
- Accepted write at edge N: oEMPTY falls, oCOUNT updates, and oRD_DATA shows the byte after edge N (first-word latency 1 cycle).
- oRD_DATA is read combinationally from mem[rd_ptr] and gated to 0 when empty. After a pop at edge N, the next entry appears after edge N.
- oFULL, oEMPTY and oCOUNT are registered and consistent in every cycle.
- oOVERRUN and oTIMEOUT are registered and set one cycle after the causing event.
- oIRQ is registered from the flag/count registers, so it lags those registers by 1 cycle.
- Reset asserted mid-operation returns every output to its reset value asynchronously. Entries in flight are lost.

## Structure
- Shared package uart_pkg holds the data width constant (8) and the default DEPTH and TIMEOUT_BITS.
- One sub-module, uart_rx_fifo_mem: DEPTH×8 register array with one synchronous write port and one asynchronous read port, no reset.
- Pointers, count, flags, timeout counter and IRQ live in uart_rx_fifo.

## Test plan
- Reset, then write 0x55, 0xA3 → oEMPTY falls 1 cycle after the first write; oRD_DATA=0x55; pop gives 0xA3; second pop leaves oEMPTY=1, oCOUNT=0.
- Fill 16 bytes, write 0x7E → oFULL=1, oOVERRUN=1 next cycle, 0x7E not stored; pop all 16 in order; iOVR_CLR clears the flag.
- Full FIFO, write 0x11 with pop in the same cycle → count stays 16, no overrun; 0x11 emerges 16th. Empty FIFO with write+pop → count=1.
- One byte buffered, 40 iRX_STOP pulses, no pop → oTIMEOUT=1 after the 40th, oIRQ the cycle after; pop clears oTIMEOUT. 39 pulses then a write → no timeout.
- iTHRESHOLD=4: write 3 bytes → oIRQ=0; 4th byte → oIRQ=1 two cycles after the write. iTHRESHOLD=0 with 16 bytes → oIRQ=0.
- Flush with a same-cycle write while holding 5 bytes → count=0, oEMPTY=1, no overrun. Assert iRESET mid-fill → all outputs at reset values immediately.
